// File: rtl/logic_shift_unit.sv
// Logic/shift execution unit: single-cycle logic ops plus iterative STEP-bits-per-cycle
// shifts, with valid/ready handshakes on both sides and a held, registered result.
module logic_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

    state_t               state_q;
    logic [WIDTH-1:0]     work_q;
    logic [WIDTH-1:0]     work_d;
    logic [SHAMT_W-1:0]   count_q;
    logic [SHAMT_W-1:0]   count_d;
    logic [1:0]           kind_q;
    logic [WIDTH-1:0]     result_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     logic_res_s;
    logic [SHAMT_W:0]     step_s;
    logic                 is_shift_s;

    // Single-cycle logic function; shift opcodes are handled by the iterative path.
    always_comb begin
        logic_res_s = '0;
        case (op_i)
            3'b000:  logic_res_s = a_i ^ b_i;
            3'b001:  logic_res_s = ~a_i;
            3'b010:  logic_res_s = a_i | b_i;
            3'b011:  logic_res_s = a_i & b_i;
            3'b111:  logic_res_s = a_i & ~b_i;
            default: logic_res_s = '0;
        endcase
    end

    // One shift step: move by min(STEP, remaining count) bits.
    always_comb begin
        step_s = STEP_W;
        work_d = work_q;
        if ({1'b0, count_q} < STEP_W) begin
            step_s = {1'b0, count_q};
        end else begin
            step_s = STEP_W;
        end
        case (kind_q)
            2'b00:   work_d = work_q << step_s;
            2'b01:   work_d = work_q >> step_s;
            2'b10:   work_d = $unsigned($signed(work_q) >>> step_s);
            default: work_d = work_q;
        endcase
        count_d = count_q - step_s[SHAMT_W-1:0];
    end

    assign is_shift_s = op_i[2] & (op_i != 3'b111);

    // Control FSM with registered result and out_valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            work_q      <= '0;
            count_q     <= '0;
            kind_q      <= 2'b00;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        if (is_shift_s) begin
                            work_q  <= a_i;
                            count_q <= b_i[SHAMT_W-1:0];
                            kind_q  <= op_i[1:0];
                            if (b_i[SHAMT_W-1:0] == '0) begin
                                result_q    <= a_i;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                state_q <= SHIFT;
                            end
                        end else begin
                            result_q    <= logic_res_s;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q  <= work_d;
                    count_q <= count_d;
                    if (count_d == '0) begin
                        result_q    <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // in_ready drops immediately while reset is held.
    assign in_ready_o  = (state_q == IDLE) & ~rst_i;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_shift_unit.sv
// Bench for logic_shift_unit: STEP=1 and STEP=4 instances share stimulus; a scoreboard
// holds expected result and latency per instance.
module tb_logic_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        rdy1, ov1, busy1, rdy4, ov4, busy4;
    logic [31:0] res1, res4;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp1_q[$];
    exp_t exp4_q[$];

    always #5 clk = ~clk;

    logic_shift_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .op_i(op), .a_i(a), .b_i(b), .out_valid_o(ov1), .out_ready_i(out_ready),
        .result_o(res1), .busy_o(busy1)
    );

    logic_shift_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .op_i(op), .a_i(a), .b_i(b), .out_valid_o(ov4), .out_ready_i(out_ready),
        .result_o(res4), .busy_o(busy4)
    );

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] r;
        r = x;
        case (o)
            3'b000: r = x ^ y;
            3'b001: r = ~x;
            3'b010: r = x | y;
            3'b011: r = x & y;
            3'b111: r = x & ~y;
            default: begin
                for (int i = 0; i < int'(y[4:0]); i++) begin
                    if (o == 3'b100)      r = {r[30:0], 1'b0};
                    else if (o == 3'b101) r = {1'b0, r[31:1]};
                    else                  r = {r[31], r[31:1]};
                end
            end
        endcase
        return r;
    endfunction

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy1 && rdy4) break;
        end
        if (i == 100) begin
            n_err++;
            $display("FAIL wait_idle: in_ready1=%b in_ready4=%b, required 1/1", rdy1, rdy4);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_res);
        exp_t e;
        int   sh;
        bit   d1, d4;
        bit   sft;
        d1  = 1'b0;
        d4  = 1'b0;
        sh  = int'(y[4:0]);
        sft = o[2] && (o != 3'b111);
        wait_idle();
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        e.res = exp_res;
        e.lat = sft ? 1 + sh : 1;
        exp1_q.push_back(e);
        e.lat = sft ? 1 + (sh + 3) / 4 : 1;
        exp4_q.push_back(e);
        in_valid = 1'b0; op = ~o; a = ~x; b = ~y;
        for (int cyc = 1; cyc <= 80 && !(d1 && d4); cyc++) begin
            @(negedge clk);
            if (ov1 && !d1) begin
                d1 = 1'b1;
                e = exp1_q.pop_front();
                n_vec++;
                if (res1 !== e.res) begin
                    n_err++;
                    $display("FAIL op%b s1 result: got %h, required %h", o, res1, e.res);
                end
                n_vec++;
                if (cyc != e.lat) begin
                    n_err++;
                    $display("FAIL op%b s1 latency: got %0d, required %0d", o, cyc, e.lat);
                end
            end
            if (ov4 && !d4) begin
                d4 = 1'b1;
                e = exp4_q.pop_front();
                n_vec++;
                if (res4 !== e.res) begin
                    n_err++;
                    $display("FAIL op%b s4 result: got %h, required %h", o, res4, e.res);
                end
                n_vec++;
                if (cyc != e.lat) begin
                    n_err++;
                    $display("FAIL op%b s4 latency: got %0d, required %0d", o, cyc, e.lat);
                end
            end
            @(posedge clk);
        end
        if (!d1) begin
            n_err++;
            e = exp1_q.pop_front();
            $display("FAIL op%b s1 timeout: out_valid 0, required 1", o);
        end
        if (!d4) begin
            n_err++;
            e = exp4_q.pop_front();
            $display("FAIL op%b s4 timeout: out_valid 0, required 1", o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ov1, busy1, rdy1, ov4, busy4, rdy4} !== 6'b0 || res1 !== 32'h0 || res4 !== 32'h0) begin
            n_err++;
            $display("FAIL reset state: ov/busy/rdy=%b%b%b %b%b%b res=%h %h, required all 0",
                     ov1, busy1, rdy1, ov4, busy4, rdy4, res1, res4);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (!(rdy1 === 1'b1 && rdy4 === 1'b1 && busy1 === 1'b0 && busy4 === 1'b0)) begin
            n_err++;
            $display("FAIL reset release: rdy=%b %b busy=%b %b, required 1 1 0 0",
                     rdy1, rdy4, busy1, busy4);
        end
    endtask

    task automatic test_legacy();
        do_op(3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        do_op(3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0F0F_FF00);
        do_op(3'b010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        do_op(3'b011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        do_op(3'b111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF000_00F0);
    endtask

    task automatic test_shift();
        do_op(3'b110, 32'h8000_0010, 32'd4, 32'hF800_0001);
        do_op(3'b101, 32'h8000_0010, 32'd4, 32'h0800_0001);
        do_op(3'b100, 32'h0000_0001, 32'd31, 32'h8000_0000);
        do_op(3'b100, 32'h0000_0001, 32'd10, 32'h0000_0400);
        do_op(3'b100, 32'h1234_5678, 32'd0, 32'h1234_5678);
        do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFE3, 32'h1000_0000);
        do_op(3'b110, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            do_op(o, x, y, model(o, x, y));
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        ok = 1'b1;
        wait_idle();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b000; a = 32'hF0F0_00FF; b = 32'h0FF0_0F0F;
        @(posedge clk);
        #1;
        e.res = 32'hFF00_0FF0;
        e.lat = 1;
        exp1_q.push_back(e);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op = 3'b011;
            a = $urandom;
            @(negedge clk);
            if (!(ov1 === 1'b1 && ov4 === 1'b1 && rdy1 === 1'b0 && rdy4 === 1'b0 &&
                  res1 === exp1_q[0].res && res4 === exp1_q[0].res)) ok = 1'b0;
        end
        in_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL backpressure hold: ov=%b %b rdy=%b %b res=%h %h, required 1 1 0 0 %h",
                     ov1, ov4, rdy1, rdy4, res1, res4, exp1_q[0].res);
        end
        out_ready = 1'b1;
        @(negedge clk);
        e = exp1_q.pop_front();
        n_vec++;
        if (!(ov1 === 1'b0 && ov4 === 1'b0 && rdy1 === 1'b1 && rdy4 === 1'b1 &&
              res1 === e.res && res4 === e.res)) begin
            n_err++;
            $display("FAIL backpressure release: ov=%b %b rdy=%b %b res=%h %h, required 0 0 1 1 %h",
                     ov1, ov4, rdy1, rdy4, res1, res4, e.res);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n4;
        n1 = 0;
        n4 = 0;
        wait_idle();
        in_valid = 1'b1; op = 3'b010; a = 32'h0000_00F0; b = 32'h0000_000F;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov1) n1++;
            if (ov4) n4++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (n1 != 3 || n4 != 3) begin
            n_err++;
            $display("FAIL back_to_back results: got %0d/%0d in 6 cycles, required 3/3", n1, n4);
        end
        n_vec++;
        if (res1 !== 32'h0000_00FF || res4 !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL back_to_back value: got %h %h, required 000000ff", res1, res4);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        seen = 1'b0;
        wait_idle();
        in_valid = 1'b1; op = 3'b101; a = 32'hA5A5_0000; b = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy1 !== 1'b1 || busy4 !== 1'b1 || ov1 !== 1'b0 || ov4 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_shift busy: busy=%b %b ov=%b %b, required 1 1 0 0", busy1, busy4, ov1, ov4);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy1, busy4, ov1, ov4, rdy1, rdy4} !== 6'b0 || res1 !== 32'h0 || res4 !== 32'h0) begin
            n_err++;
            $display("FAIL mid_shift reset: busy=%b %b ov=%b %b rdy=%b %b res=%h %h, required all 0",
                     busy1, busy4, ov1, ov4, rdy1, rdy4, res1, res4);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov1 || ov4) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL mid_shift aborted: out_valid seen 1, required 0");
        end
        do_op(3'b110, 32'h8000_0010, 32'd4, 32'hF800_0001);
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
